// File: rtl/divseq_pkg.sv
// rtl/divseq_pkg.sv - shared state encoding and default widths for divider_sequencer
package divseq_pkg;

    localparam int DEF_RATIO_W   = 4;
    localparam int DEF_PERIODS_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } state_t;

endpackage

// File: rtl/divider_sequencer_if.sv
// rtl/divider_sequencer_if.sv - control/status bundle between controller and divider sequencer
interface divider_sequencer_if
    import divseq_pkg::*;
#(
    parameter int RATIO_W   = DEF_RATIO_W,
    parameter int PERIODS_W = DEF_PERIODS_W
);
    logic                 start;
    logic                 stop;
    logic [RATIO_W-1:0]   ratio;
    logic                 div_out;
    logic                 tick;
    logic                 busy;
    logic                 done;
    logic [PERIODS_W-1:0] periods;

    modport master (
        output start, stop, ratio,
        input  div_out, tick, busy, done, periods
    );

    modport slave (
        input  start, stop, ratio,
        output div_out, tick, busy, done, periods
    );
endinterface

// File: rtl/divider_sequencer_ratio_counter.sv
// rtl/divider_sequencer_ratio_counter.sv - clearable modulo-R counter with wrap flag
module ratio_counter #(
    parameter int RATIO_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [RATIO_W-1:0] ratio_q,
    output logic               wrap
);
    logic [RATIO_W-1:0] count_q;
    logic [RATIO_W-1:0] count_d;

    // wrap fires on the last count of a half-period; ratio_q is never 0
    assign wrap = enable && (count_q == (ratio_q - RATIO_W'(1)));

    // next count: clear wins, otherwise advance and fold back to 0 on wrap
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = wrap ? '0 : count_q + RATIO_W'(1);
        end
    end

    // count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - start/run/clean-stop controller for the toggle-flop clock divider
module divider_sequencer
    import divseq_pkg::*;
#(
    parameter int RATIO_W   = DEF_RATIO_W,
    parameter int PERIODS_W = DEF_PERIODS_W
) (
    input logic                 clock,
    input logic                 reset,
    divider_sequencer_if.slave  bus
);
    localparam logic [PERIODS_W-1:0] PERIODS_MAX = '1;

    state_t               state_q, state_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic                 div_q, div_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [PERIODS_W-1:0] periods_q, periods_d;
    logic                 cnt_clear;
    logic                 cnt_enable;
    logic                 wrap;

    ratio_counter #(.RATIO_W(RATIO_W)) u_ratio_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .ratio_q (ratio_q),
        .wrap    (wrap)
    );

    // FSM next state plus the divided-clock, pulse and period-count updates
    always_comb begin
        state_d    = state_q;
        ratio_d    = ratio_q;
        div_d      = div_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        periods_d  = periods_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ratio_d   = (bus.ratio == '0) ? RATIO_W'(1) : bus.ratio;
                    periods_d = '0;
                    cnt_clear = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN, STOPPING: begin
                cnt_enable = 1'b1;
                if (wrap) begin
                    div_d  = ~div_q;
                    tick_d = 1'b1;
                    // a falling edge completes one output period
                    if (div_q && periods_q != PERIODS_MAX) begin
                        periods_d = periods_q + PERIODS_W'(1);
                    end
                end
                if (state_q == RUN) begin
                    if (bus.stop) begin
                        state_d = STOPPING;
                    end
                end else if (wrap && div_q) begin
                    // finish only on a falling edge so the last high phase is whole
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == STOPPING);
    end

    // state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ratio_q   <= RATIO_W'(1);
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            periods_q <= '0;
        end else begin
            state_q   <= state_d;
            ratio_q   <= ratio_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            periods_q <= periods_d;
        end
    end

    assign bus.div_out = div_q;
    assign bus.tick    = tick_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.periods = periods_q;
endmodule
